spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
- Parametrised command/control FSM for the SPI slave, successor to the single-byte-address controller.
- Decodes an opcode, collects a multi-byte address, then runs wrapping burst writes, burst reads or status reads against the register file.
- Flags illegal opcodes.
- Sits between the SPI shift register/bit counter and the register file.
- All CS handling is synchronous to i_clk.

Parameters:
- DATA_WIDTH, 8, byte width of shift register and register file.
- ADDR_BYTES, 1, number of address bytes sent MSB first (1..4). ADDR_WIDTH = ADDR_BYTES*DATA_WIDTH (localparam).
- DEPTH, 256, register-file depth; burst addresses wrap modulo DEPTH (power of 2, ≤ 2^ADDR_WIDTH).
- OP_WRITE, 8'h02, burst write opcode.
- OP_READ, 8'h03, burst read opcode.
- OP_RDSR, 8'h05, status read opcode.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_spi_cs  in  1  chip select, active-low, already synchronised to i_clk.
- i_byte_ready  in  1  one-cycle pulse: i_rx_byte holds a complete received byte.
- i_rx_byte  in  DATA_WIDTH  received byte.
- i_status  in  DATA_WIDTH  status word returned by OP_RDSR.
- o_address  out  ADDR_WIDTH  register-file address.
- o_wdata  out  DATA_WIDTH  write data, valid with o_wr_en.
- o_wr_en  out  1  one-cycle register-file write strobe.
- o_rd_en  out  1  one-cycle register-file read strobe.
- o_par_load  out  1  parallel-load strobe to the TX shift register.
- o_tx_sel  out  1  TX load source: 0 = register file, 1 = i_status.
- o_shift_en  out  1  shift enable (= ~i_spi_cs).
- o_count_en  out  1  bit-counter enable (= ~i_spi_cs).
- o_count_clr  out  1  bit-counter clear; 1 in IDLE.
- o_busy  out  1  state != IDLE.
- o_cmd_err  out  1  illegal opcode seen; holds until next CS assertion.
- o_done  out  1  one-cycle pulse when CS deasserts from a non-IDLE state.

Behaviour:
- Reset values: o_address=0, o_wdata=0, o_tx_sel=0, o_cmd_err=0, state IDLE, all strobes 0. o_count_clr=1 (IDLE).
- Reset may assert at any time: async return to IDLE and clears the address register and byte counters. No strobe may fire after reset assertion.
- States: IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGNORE.
- IDLE:
  - Any cycle with i_spi_cs=0 -> CMD.
  - o_cmd_err clears on that transition.
- CMD, on i_byte_ready:
  - OP_WRITE or OP_READ -> ADDR; address byte counter cleared.
  - OP_RDSR -> STAT. Next cycle: o_tx_sel=1, o_par_load=1.
  - Any other opcode -> IGNORE; o_cmd_err=1 next cycle.
- ADDR:
  - Each i_byte_ready shifts i_rx_byte into the address register MSB first.
  - After ADDR_BYTES bytes: write -> WDATA; read -> RDATA.
  - On entry to RDATA, next cycle: o_rd_en=1, o_par_load=1, o_tx_sel=0, o_address=received address.
- WDATA, each i_byte_ready:
  - Next cycle: o_wdata=byte, o_wr_en=1 at the current o_address.
  - The cycle after the strobe, address increments.
- RDATA, each i_byte_ready:
  - Address increments.
  - Next cycle: o_rd_en=1, o_par_load=1 at the new address.
- Wrap: address DEPTH-1 increments to 0. The upper address bits above log2(DEPTH) are preserved.
- STAT: each i_byte_ready -> next cycle o_par_load=1 with o_tx_sel=1 (repeated status). No rd/wr.
- IGNORE: no strobes; shift/count continue until CS rises.
- i_spi_cs=1 in any non-IDLE state -> IDLE next cycle; o_done pulses one cycle.
- Simultaneous i_byte_ready and CS rise: the byte is fully processed (a pending write still strobes), then IDLE.
- CS rise during ADDR: no access occurs.
- Latency: byte_ready to any strobe = 1 cycle.
- o_wr_en, o_rd_en and o_par_load never assert in the same cycle except rd_en+par_load.

Optional Feature:
- SPI_FAST_READ_EN defined:
  - Adds opcode 8'h0B (fast read): address bytes, then one dummy byte (state DUMMY, no strobes), then RDATA.
  - The first o_rd_en/o_par_load fires 1 cycle after the dummy byte's i_byte_ready.
- SPI_FAST_READ_EN undefined: 8'h0B is illegal (IGNORE, o_cmd_err=1).

Test Plan:
- Write burst, ADDR_BYTES=1: CS low; bytes 02,10,AA,BB,CC; CS high -> o_wr_en at addr 10/11/12 with data AA/BB/CC; o_done one pulse; o_busy=0.
- Read burst with wrap, DEPTH=256: bytes 03,FE,xx,xx -> o_rd_en+o_par_load at FE, then FF, then 00; o_tx_sel=0 throughout.
- Status read: i_status=5A; bytes 05,xx,xx -> o_par_load with o_tx_sel=1 after each byte (3 pulses); no o_rd_en/o_wr_en.
- Illegal opcode 7E, then CS high/low -> o_cmd_err=1 during the frame, no strobes; o_cmd_err=0 after the new CS assertion.
- ADDR_BYTES=2: bytes 02,12,34,55 -> o_wr_en at o_address=1234 with o_wdata=55. CS rises in the same cycle as the 4th i_byte_ready: write still occurs, then IDLE.
- Reset mid-burst: i_rst low during WDATA -> IDLE immediately, o_address=0, no further o_wr_en. SPI_FAST_READ_EN: 0B,20,dummy,xx -> first o_rd_en at 20 after the dummy byte.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// Command/control FSM for the SPI slave: opcode decode, multi-byte address, wrapping bursts.
// Define SPI_FAST_READ_EN to accept the 0x0B fast-read opcode (address, one dummy byte, data).
module spi_cmd_ctrl #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_BYTES = 1,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'('h02),
    parameter logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'('h03),
    parameter logic [DATA_WIDTH-1:0] OP_RDSR    = DATA_WIDTH'('h05),
    localparam int unsigned          ADDR_WIDTH = ADDR_BYTES * DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_spi_cs,
    input  logic                  i_byte_ready,
    input  logic [DATA_WIDTH-1:0] i_rx_byte,
    input  logic [DATA_WIDTH-1:0] i_status,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic                  o_par_load,
    output logic                  o_tx_sel,
    output logic                  o_shift_en,
    output logic                  o_count_en,
    output logic                  o_count_clr,
    output logic                  o_busy,
    output logic                  o_cmd_err,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            LAST_ADDR = 2'(ADDR_BYTES - 1);
`ifdef SPI_FAST_READ_EN
    localparam logic [DATA_WIDTH-1:0] OP_FAST_READ = DATA_WIDTH'('h0B);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StRdata,
        StStat,
        StIgnore
`ifdef SPI_FAST_READ_EN
        , StDummy
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    par_load_q, par_load_d;
    logic                    tx_sel_q, tx_sel_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    done_q, done_d;
`ifdef SPI_FAST_READ_EN
    logic                    is_fast_q, is_fast_d;
`endif

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_shift_full;
    logic [ADDR_WIDTH-1:0]            addr_inc;

    // Status data goes straight to the TX mux outside; only o_tx_sel is produced here.
    logic unused_status;
    assign unused_status = ^i_status;

    assign addr_shift_full = {address_q, i_rx_byte};
    // Only the low log2(DEPTH) bits count; upper address bits are preserved across wrap.
    assign addr_inc = (address_q & ~ADDR_MASK) | ((address_q + ADDR_WIDTH'(1)) & ADDR_MASK);

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        tx_sel_d   = tx_sel_q;
        cmd_err_d  = cmd_err_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        par_load_d = 1'b0;
        done_d     = 1'b0;
`ifdef SPI_FAST_READ_EN
        is_fast_d  = is_fast_q;
`endif

        if (wr_en_q) begin
            address_d = addr_inc;
        end

        unique case (state_q)
            StIdle: begin
                if (!i_spi_cs) begin
                    state_d   = StCmd;
                    cmd_err_d = 1'b0;
                end
            end
            StCmd: begin
                if (i_byte_ready) begin
                    if (i_rx_byte == OP_WRITE || i_rx_byte == OP_READ) begin
                        state_d    = StAddr;
                        cnt_d      = 2'd0;
                        is_write_d = (i_rx_byte == OP_WRITE);
`ifdef SPI_FAST_READ_EN
                        is_fast_d  = 1'b0;
                    end else if (i_rx_byte == OP_FAST_READ) begin
                        state_d    = StAddr;
                        cnt_d      = 2'd0;
                        is_write_d = 1'b0;
                        is_fast_d  = 1'b1;
`endif
                    end else if (i_rx_byte == OP_RDSR) begin
                        state_d    = StStat;
                        par_load_d = 1'b1;
                        tx_sel_d   = 1'b1;
                    end else begin
                        state_d   = StIgnore;
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (i_byte_ready) begin
                    address_d = addr_shift_full[ADDR_WIDTH-1:0];
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == LAST_ADDR) begin
                        if (is_write_q) begin
                            state_d = StWdata;
`ifdef SPI_FAST_READ_EN
                        end else if (is_fast_q) begin
                            state_d = StDummy;
`endif
                        end else begin
                            state_d = StRdata;
                            // A frame ending on the last address byte performs no access.
                            rd_en_d    = ~i_spi_cs;
                            par_load_d = ~i_spi_cs;
                            tx_sel_d   = 1'b0;
                        end
                    end
                end
            end
            StWdata: begin
                if (i_byte_ready) begin
                    wdata_d = i_rx_byte;
                    wr_en_d = 1'b1;
                end
            end
            StRdata: begin
                if (i_byte_ready) begin
                    address_d  = addr_inc;
                    rd_en_d    = 1'b1;
                    par_load_d = 1'b1;
                    tx_sel_d   = 1'b0;
                end
            end
            StStat: begin
                if (i_byte_ready) begin
                    par_load_d = 1'b1;
                    tx_sel_d   = 1'b1;
                end
            end
`ifdef SPI_FAST_READ_EN
            StDummy: begin
                if (i_byte_ready) begin
                    state_d    = StRdata;
                    rd_en_d    = 1'b1;
                    par_load_d = 1'b1;
                    tx_sel_d   = 1'b0;
                end
            end
`endif
            StIgnore: begin
            end
            default: state_d = StIdle;
        endcase

        // CS rise wins over the state change but the byte above is still processed.
        if (state_q != StIdle && i_spi_cs) begin
            state_d = StIdle;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            address_q  <= '0;
            wdata_q    <= '0;
            cnt_q      <= 2'd0;
            is_write_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            par_load_q <= 1'b0;
            tx_sel_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_FAST_READ_EN
            is_fast_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            par_load_q <= par_load_d;
            tx_sel_q   <= tx_sel_d;
            cmd_err_q  <= cmd_err_d;
            done_q     <= done_d;
`ifdef SPI_FAST_READ_EN
            is_fast_q  <= is_fast_d;
`endif
        end
    end

    assign o_address   = address_q;
    assign o_wdata     = wdata_q;
    assign o_wr_en     = wr_en_q;
    assign o_rd_en     = rd_en_q;
    assign o_par_load  = par_load_q;
    assign o_tx_sel    = tx_sel_q;
    assign o_shift_en  = ~i_spi_cs;
    assign o_count_en  = ~i_spi_cs;
    assign o_count_clr = (state_q == StIdle);
    assign o_busy      = (state_q != StIdle);
    assign o_cmd_err   = cmd_err_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: one instance with 1 address byte, one with 2.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       byte_ready;
    logic [7:0] rx_byte;
    logic [7:0] status;

    logic [7:0]  a_address;
    logic [7:0]  a_wdata;
    logic        a_wr_en, a_rd_en, a_par_load, a_tx_sel, a_shift_en, a_count_en;
    logic        a_count_clr, a_busy, a_cmd_err, a_done;
    logic [15:0] b_address;
    logic [7:0]  b_wdata;
    logic        b_wr_en, b_rd_en, b_par_load, b_tx_sel, b_shift_en, b_count_en;
    logic        b_count_clr, b_busy, b_cmd_err, b_done;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, rd_cnt = 0, par_cnt = 0, done_cnt = 0;
    int base_wr, base_rd, base_par, base_done;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.ADDR_BYTES(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_spi_cs(cs), .i_byte_ready(byte_ready),
        .i_rx_byte(rx_byte), .i_status(status), .o_address(a_address), .o_wdata(a_wdata),
        .o_wr_en(a_wr_en), .o_rd_en(a_rd_en), .o_par_load(a_par_load), .o_tx_sel(a_tx_sel),
        .o_shift_en(a_shift_en), .o_count_en(a_count_en), .o_count_clr(a_count_clr),
        .o_busy(a_busy), .o_cmd_err(a_cmd_err), .o_done(a_done)
    );

    spi_cmd_ctrl #(.ADDR_BYTES(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_spi_cs(cs), .i_byte_ready(byte_ready),
        .i_rx_byte(rx_byte), .i_status(status), .o_address(b_address), .o_wdata(b_wdata),
        .o_wr_en(b_wr_en), .o_rd_en(b_rd_en), .o_par_load(b_par_load), .o_tx_sel(b_tx_sel),
        .o_shift_en(b_shift_en), .o_count_en(b_count_en), .o_count_clr(b_count_clr),
        .o_busy(b_busy), .o_cmd_err(b_cmd_err), .o_done(b_done)
    );

    always @(negedge clk) begin
        if (a_wr_en)    wr_cnt++;
        if (a_rd_en)    rd_cnt++;
        if (a_par_load) par_cnt++;
        if (a_done)     done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the negedge of the cycle where the resulting strobe is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_ready = 1'b1;
        rx_byte    = b;
        @(negedge clk);
        byte_ready = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; cs = 1'b1; byte_ready = 1'b0; rx_byte = 8'h00; status = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_address", a_address, 32'h0);
        check("rst_wdata", a_wdata, 32'h0);
        check("rst_tx_sel", a_tx_sel, 32'h0);
        check("rst_cmd_err", a_cmd_err, 32'h0);
        check("rst_strobes", {a_wr_en, a_rd_en, a_par_load, a_done}, 32'h0);
        check("rst_count_clr", a_count_clr, 32'h1);
        check("rst_busy", a_busy, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Write burst
        base_wr = wr_cnt;
        frame_start();
        check("cs_shift_en", {a_shift_en, a_count_en, a_count_clr, a_busy}, 32'b1101);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'hAA);
        check("wr0_en", a_wr_en, 32'h1);
        check("wr0_addr", a_address, 32'h10);
        check("wr0_data", a_wdata, 32'hAA);
        check("wr0_no_rd", {a_rd_en, a_par_load}, 32'h0);
        @(negedge clk);
        check("wr0_inc", a_address, 32'h11);
        check("wr0_pulse", a_wr_en, 32'h0);
        send_byte(8'hBB);
        check("wr1", {a_wr_en, a_address, a_wdata}, {1'b1, 8'h11, 8'hBB});
        send_byte(8'hCC);
        check("wr2", {a_wr_en, a_address, a_wdata}, {1'b1, 8'h12, 8'hCC});
        base_done = done_cnt;
        cs = 1'b1;
        @(negedge clk);
        check("wr_done", a_done, 32'h1);
        check("wr_busy", a_busy, 32'h0);
        repeat (3) @(negedge clk);
        check("wr_done_once", done_cnt - base_done, 32'd1);
        check("wr_count", wr_cnt - base_wr, 32'd3);
        check("idle_count_clr", a_count_clr, 32'h1);

        // Read burst with wrap
        base_wr = wr_cnt; base_rd = rd_cnt;
        frame_start();
        send_byte(8'h03);
        send_byte(8'hFE);
        check("rd0", {a_rd_en, a_par_load, a_tx_sel, a_address}, {3'b110, 8'hFE});
        send_byte(8'h00);
        check("rd1", {a_rd_en, a_par_load, a_tx_sel, a_address}, {3'b110, 8'hFF});
        send_byte(8'h00);
        check("rd2_wrap", {a_rd_en, a_par_load, a_tx_sel, a_address}, {3'b110, 8'h00});
        frame_end();
        check("rd_count", rd_cnt - base_rd, 32'd3);
        check("rd_no_wr", wr_cnt - base_wr, 32'd0);

        // Status read
        base_wr = wr_cnt; base_rd = rd_cnt; base_par = par_cnt;
        frame_start();
        send_byte(8'h05);
        check("st0", {a_par_load, a_tx_sel, a_rd_en}, 32'b110);
        send_byte(8'h00);
        check("st1", {a_par_load, a_tx_sel}, 32'b11);
        send_byte(8'h00);
        check("st2", {a_par_load, a_tx_sel}, 32'b11);
        frame_end();
        check("st_par_count", par_cnt - base_par, 32'd3);
        check("st_no_rdwr", (rd_cnt - base_rd) + (wr_cnt - base_wr), 32'd0);

        // Illegal opcode
        base_wr = wr_cnt; base_rd = rd_cnt; base_par = par_cnt;
        frame_start();
        send_byte(8'h7E);
        check("ill_err", a_cmd_err, 32'h1);
        send_byte(8'h00);
        frame_end();
        check("ill_err_hold", a_cmd_err, 32'h1);
        check("ill_no_strobe", (wr_cnt - base_wr) + (rd_cnt - base_rd) + (par_cnt - base_par),
              32'd0);
        cs = 1'b0;
        @(negedge clk);
        check("ill_err_clr", a_cmd_err, 32'h0);
        frame_end();

        // Two address bytes; CS rises with the data byte
        frame_start();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        byte_ready = 1'b1; rx_byte = 8'h55; cs = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        check("ab2_wr", {b_wr_en, b_address, b_wdata}, {1'b1, 16'h1234, 8'h55});
        check("ab2_idle", {b_busy, b_done}, 32'b01);
        repeat (3) @(negedge clk);

        // Reset mid-burst, asserted in the strobe cycle
        frame_start();
        send_byte(8'h02);
        send_byte(8'h40);
        send_byte(8'h11);
        check("rm_wr", {a_wr_en, a_address}, {1'b1, 8'h40});
        rst = 1'b0;
        #1;
        check("rm_no_wr", a_wr_en, 32'h0);
        check("rm_addr", a_address, 32'h0);
        check("rm_idle", {a_busy, a_count_clr}, 32'b01);
        base_wr = wr_cnt;
        send_byte(8'h22);
        repeat (2) @(negedge clk);
        check("rm_wr_count", wr_cnt - base_wr, 32'd0);
        cs = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Fast read opcode
        frame_start();
        send_byte(8'h0B);
`ifdef SPI_FAST_READ_EN
        send_byte(8'h20);
        check("fr_dummy_quiet", {a_rd_en, a_par_load}, 32'h0);
        send_byte(8'h00);
        check("fr_rd0", {a_rd_en, a_par_load, a_tx_sel, a_address}, {3'b110, 8'h20});
        send_byte(8'h00);
        check("fr_rd1", {a_rd_en, a_address}, {1'b1, 8'h21});
`else
        check("fr_illegal", a_cmd_err, 32'h1);
        send_byte(8'h20);
        check("fr_no_rd", {a_rd_en, a_par_load}, 32'h0);
`endif
        frame_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
